sccb_target_regs: RTL and testbench

//  SCCB/I2C responder: the camera-side end of the SCCB write bus. Oversamples SCL/SDA on clk, decodes

---
 rtl/sccb_pkg.sv | 21 ++
 rtl/sccb_line_sync.sv | 54 +++++
 rtl/sccb_target_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_sccb_target_regs.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target register block.
// Holds the target FSM state enum and byte/R-W framing constants.
package sccb_pkg;

  localparam int unsigned SCCB_BITS_PER_BYTE = 8;
  localparam logic        SCCB_RW_READ       = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StDevId,
    StAckId,
    StSubAddr,
    StAckAddr,
    StWrData,
    StAckData,
    StRdData,
    StRdAck,
    StIgnore
  } sccb_tgt_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchronizers plus one edge flop per line, producing single-clk protocol events.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   scl_i/sda_i  asynchronous pin levels
//   scl_rise_o   synced SCL 0->1
//   scl_fall_o   synced SCL 1->0
//   sda_s_o      synced SDA level
//   start_det_o  SDA fall while SCL high
//   stop_det_o   SDA rise while SCL high
module sccb_line_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_s_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  scl_s, sda_s;

  // Reset to the idle-bus level (both high) so no event fires as reset releases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SyncStages-1];
  assign sda_s = sda_sync_q[SyncStages-1];

  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  assign sda_s_o     = sda_s;
  // SCL must be high on both samples so an SDA change racing an SCL edge is not a START/STOP.
  assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_target_regs.sv
// SCCB/I2C write-bus responder with a 256x8 register file (camera stand-in).
// Decodes START/ID/sub-address/data/STOP, ACKs by pulling SDA low, stores written bytes.
// Optional feature macro: SCCB_TARGET_READ_EN enables the 2-phase read (ID with R/W=1).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   scl_in, sda_in       asynchronous bus pin levels
//   sda_oe               1 = pull SDA low
//   busy                 START seen, STOP not yet seen
//   wr_valid/addr/data   one-clk pulse per accepted data byte
//   host_addr/host_data  combinational side read port
module sccb_target_regs
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data
);

  localparam logic [3:0] BitsPerByte = 4'(SCCB_BITS_PER_BYTE);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  sccb_line_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .sda_s_o    (sda_s),
    .start_det_o(start_det),
    .stop_det_o (stop_det)
  );

  sccb_tgt_state_e state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_valid_q, wr_valid_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            reg_we;
  logic            rw_ok;
  logic [7:0]      ptr_inc;
  logic [7:0]      regs_q [256];

  assign ptr_inc = ptr_q + 8'd1;

`ifdef SCCB_TARGET_READ_EN
  logic [7:0] rd_cur, rd_nxt;
  assign rd_cur = regs_q[ptr_q];
  assign rd_nxt = regs_q[ptr_inc];
  assign rw_ok  = 1'b1;
`else
  // Without read support a read ID is treated as not ours: no ACK.
  assign rw_ok = (shift_q[0] != SCCB_RW_READ);
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    // START/STOP win over any bit activity, dropping a partial byte.
    if (start_det) begin
      state_d   = StDevId;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        StDevId, StSubAddr, StWrData: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            bit_cnt_d = '0;
            if (state_q == StDevId) begin
              if (shift_q[7:1] == DEV_ADDR && rw_ok) begin
                rw_d     = shift_q[0];
                sda_oe_d = 1'b1;
                state_d  = StAckId;
              end else begin
                state_d = StIgnore;
              end
            end else if (state_q == StSubAddr) begin
              ptr_d    = shift_q;
              sda_oe_d = 1'b1;
              state_d  = StAckAddr;
            end else begin
              reg_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_q;
              ptr_d      = ptr_inc;
              sda_oe_d   = 1'b1;
              state_d    = StAckData;
            end
          end
        end
        StAckId: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
`ifdef SCCB_TARGET_READ_EN
            if (rw_q == SCCB_RW_READ) begin
              // First read bit goes out on the same fall that ends the ACK.
              sda_oe_d = ~rd_cur[7];
              shift_d  = {rd_cur[6:0], 1'b0};
              state_d  = StRdData;
            end else begin
              state_d = StSubAddr;
            end
`else
            state_d = (rw_q == SCCB_RW_READ) ? StIgnore : StSubAddr;
`endif
          end
        end
        StAckAddr, StAckData: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StWrData;
          end
        end
`ifdef SCCB_TARGET_READ_EN
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == BitsPerByte) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdAck;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          // shift_q[0] holds the master's ACK bit during this slot.
          if (scl_rise) begin
            shift_d[0] = sda_s;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (!shift_q[0]) begin
              ptr_d    = ptr_inc;
              sda_oe_d = ~rd_nxt[7];
              shift_d  = {rd_nxt[6:0], 1'b0};
              state_d  = StRdData;
            end else begin
              state_d = StIgnore;
            end
          end
        end
`endif
        StIdle, StIgnore: ;
        default: begin
          sda_oe_d = 1'b0;
          state_d  = StIgnore;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  // Combinational read: a same-clk bus write is visible only after the edge.
  assign host_data = regs_q[host_addr];
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_sccb_target_regs.sv
module tb_sccb_target_regs;

`ifdef SCCB_TARGET_READ_EN
  localparam bit ReadEn = 1'b1;
`else
  localparam bit ReadEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl, msda;
  logic       sda_in;
  logic       sda_oe, busy, wr_valid;
  logic [7:0] wr_addr, wr_data, host_addr, host_data;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low.
  assign sda_in = msda & ~sda_oe;

  sccb_target_regs dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .host_addr(host_addr),
    .host_data(host_data)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  model_regs [256];
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic        oe_seen;

  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    msda = 1'b1; wait_clks(5);
    scl  = 1'b1; wait_clks(10);
    msda = 1'b0; wait_clks(10);
    scl  = 1'b0; wait_clks(5);
  endtask

  task automatic bus_stop();
    msda = 1'b0; wait_clks(5);
    scl  = 1'b1; wait_clks(10);
    msda = 1'b1; wait_clks(10);
  endtask

  // One SCL period; returns the SDA level seen mid-high.
  task automatic send_bit(input logic b, output logic s);
    msda = b;    wait_clks(5);
    scl  = 1'b1; wait_clks(5);
    s = sda_in;  wait_clks(5);
    scl  = 1'b0; wait_clks(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int k = 7; k >= 0; k--) send_bit(b[k], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic s;
    for (int k = 7; k >= 0; k--) begin
      send_bit(1'b1, s);
      v[k] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic check_host(input logic [7:0] a);
    host_addr = a;
    #1;
    check("host_data", {8'h00, host_data}, {8'h00, model_regs[a]});
  endtask

  // Sends frame_q as a complete write frame, predicting ACKs and writes from the rules.
  task automatic send_frame();
    logic       addressed, ack;
    logic [7:0] p;
    obs_q.delete();
    exp_q.delete();
    oe_seen   = 1'b0;
    addressed = (frame_q[0] == 8'h42);
    p         = (frame_q.size() > 1) ? frame_q[1] : 8'h00;
    bus_start();
    check("busy_after_start", {15'h0, busy}, 16'h1);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], ack);
      check("byte_ack", {15'h0, ack}, {15'h0, addressed});
      if (addressed && i >= 2) begin
        model_regs[p] = frame_q[i];
        exp_q.push_back({p, frame_q[i]});
        p = p + 8'd1;
      end
    end
    bus_stop();
    wait_clks(3);
    check("busy_after_stop", {15'h0, busy}, 16'h0);
    check("oe_seen", {15'h0, oe_seen}, {15'h0, addressed});
    check("wr_count", 16'(obs_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("wr_event", obs_q[i], exp_q[i]);
    for (int i = 0; i < exp_q.size(); i++) check_host(exp_q[i][15:8]);
    check_host(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] v;
    int         len;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    reset_n = 1'b0; scl = 1'b1; msda = 1'b1; host_addr = 8'h00;
    wait_clks(4);
    reset_n = 1'b1;
    wait_clks(3);
    check("rst_sda_oe", {15'h0, sda_oe}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_wr_valid", {15'h0, wr_valid}, 16'h0);
    check("rst_wr_bus", {wr_addr, wr_data}, 16'h0000);
    check_host(8'h12);
    check_host(8'hFF);

    // Basic 3-phase write.
    frame_q = '{8'h42, 8'h12, 8'h80};
    send_frame();
    // Another device: must stay silent.
    frame_q = '{8'h60, 8'h12, 8'h99};
    send_frame();
    // Burst wrapping the pointer past 8'hFF.
    frame_q = '{8'h42, 8'hFE, 8'h11, 8'h22, 8'h33};
    send_frame();

    // STOP inside a data byte drops it.
    obs_q.delete();
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h40, ack);
    for (int k = 0; k < 4; k++) send_bit(k[0], s);
    bus_stop();
    wait_clks(3);
    check("partial_no_write", 16'(obs_q.size()), 16'h0);
    check_host(8'h40);
    frame_q = '{8'h42, 8'h40, 8'hA5};
    send_frame();

    // Random write frames, some for other device IDs.
    for (int f = 0; f < 6; f++) begin
      frame_q.delete();
      if ($urandom_range(0, 3) == 0) frame_q.push_back(8'(8'h60 + 2 * $urandom_range(0, 15)));
      else frame_q.push_back(8'h42);
      frame_q.push_back(8'($urandom_range(0, 255)));
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      send_frame();
    end

    // Read path (ACKed only with read support).
    frame_q = '{8'h42, 8'h0A, 8'h76};
    send_frame();
    bus_start();
    send_byte(8'h42, ack);
    check("rd_id_w_ack", {15'h0, ack}, 16'h1);
    send_byte(8'h0A, ack);
    check("rd_sub_ack", {15'h0, ack}, 16'h1);
    bus_start();
    send_byte(8'h43, ack);
    check("rd_id_r_ack", {15'h0, ack}, {15'h0, ReadEn});
    if (ack) begin
      read_byte(1'b0, v);
      check("rd_byte0", {8'h00, v}, {8'h00, model_regs[8'h0A]});
      read_byte(1'b1, v);
      check("rd_byte1", {8'h00, v}, {8'h00, model_regs[8'h0B]});
    end
    bus_stop();
    wait_clks(3);
    check("rd_busy_after_stop", {15'h0, busy}, 16'h0);
    check("rd_released", {15'h0, sda_oe}, 16'h0);

    // Reset asserted while the target is ACKing a data byte.
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h40, ack);
    for (int k = 7; k >= 0; k--) send_bit(v[k] ^ 1'b1, s);
    msda = 1'b1; wait_clks(5);
    scl  = 1'b1; wait_clks(3);
    check("pre_rst_ack_oe", {15'h0, sda_oe}, 16'h1);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_sda_oe", {15'h0, sda_oe}, 16'h0);
    check("rst_mid_busy", {15'h0, busy}, 16'h0);
    check("rst_mid_wr_bus", {wr_addr, wr_data}, 16'h0000);
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(3);
    check_host(8'h40);
    check_host(8'h12);
    check_host(8'h0A);
    frame_q = '{8'h42, 8'h33, 8'hC3, 8'h3C};
    send_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
